// File: rtl/mau_reli_tx_flowstate_arbiter.sv
// Port-B arbiter for the reliable-TX flowstate RAM: bcd write-back passthrough,
// control-plane read/write channel and the post-reset / flush clear sweep.
module mau_reli_tx_flowstate_arbiter #(
    parameter int unsigned FLOWSTATE_WIDTH = 33,
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned RD_LATENCY      = 1,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bcd_valid,
    input  logic [ADDR_WIDTH-1:0]      bcd_addr,
    input  logic [FLOWSTATE_WIDTH-1:0] bcd_flowstate,
    input  logic                       cfg_req_valid,
    output logic                       cfg_req_ready,
    input  logic                       cfg_req_wr,
    input  logic [ADDR_WIDTH-1:0]      cfg_req_addr,
    input  logic [FLOWSTATE_WIDTH-1:0] cfg_req_wdata,
    output logic                       cfg_rsp_valid,
    input  logic                       cfg_rsp_ready,
    output logic [FLOWSTATE_WIDTH-1:0] cfg_rsp_data,
    input  logic                       flush_req,
    output logic                       mem_wr_en,
    output logic [ADDR_WIDTH-1:0]      mem_wr_addr,
    output logic [FLOWSTATE_WIDTH-1:0] mem_wr_data,
    output logic                       mem_rd_en,
    output logic [ADDR_WIDTH-1:0]      mem_rd_addr,
    input  logic [FLOWSTATE_WIDTH-1:0] mem_rd_data,
    output logic                       tbl_ready,
    output logic [CNT_WIDTH-1:0]       collision_cnt
);

    typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, RSP} state_t;

    localparam logic [1:0] RD_LAST = 2'(RD_LATENCY - 1);

    state_t                     state, state_nxt;
    logic [ADDR_WIDTH-1:0]      ptr;
    logic [ADDR_WIDTH-1:0]      rd_addr;
    logic [1:0]                 rd_cnt;
    logic                       flush_pending;
    logic                       rsp_is_read;
    logic                       byp_hit;
    logic [FLOWSTATE_WIDTH-1:0] byp_data;

    logic accept, sweep_step, sweep_last, bcd_hit, rd_capture, flush_any;

    // Port-B mux and next state; everything is gated by rst_n so the port
    // stays quiet while reset is held.
    always_comb begin
        state_nxt     = state;
        mem_wr_en     = 1'b0;
        mem_wr_addr   = bcd_addr;
        mem_wr_data   = bcd_flowstate;
        mem_rd_en     = 1'b0;
        mem_rd_addr   = cfg_req_addr;
        cfg_req_ready = 1'b0;
        accept        = 1'b0;
        sweep_step    = 1'b0;
        rd_capture    = 1'b0;
        flush_any     = flush_req || flush_pending;
        bcd_hit       = bcd_valid && (bcd_addr == rd_addr);
        sweep_last    = (ptr == '1);
        if (rst_n) begin
            if (bcd_valid) begin
                mem_wr_en = 1'b1;
            end
            unique case (state)
                INIT: begin
                    if (!bcd_valid) begin
                        sweep_step  = 1'b1;
                        mem_wr_en   = 1'b1;
                        mem_wr_addr = ptr;
                        mem_wr_data = '0;
                        if (sweep_last && !flush_req) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                IDLE: begin
                    cfg_req_ready = !bcd_valid && !flush_any;
                    accept        = cfg_req_valid && cfg_req_ready;
                    if (flush_any) begin
                        state_nxt = INIT;
                    end else if (accept) begin
                        if (cfg_req_wr) begin
                            mem_wr_en   = 1'b1;
                            mem_wr_addr = cfg_req_addr;
                            mem_wr_data = cfg_req_wdata;
                            state_nxt   = RSP;
                        end else begin
                            mem_rd_en = 1'b1;
                            state_nxt = RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (rd_cnt == RD_LAST) begin
                        rd_capture = 1'b1;
                        state_nxt  = RSP;
                    end
                end
                RSP: begin
                    if (cfg_rsp_ready) begin
                        state_nxt = flush_pending ? INIT : IDLE;
                    end
                end
                default: state_nxt = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= INIT;
            ptr           <= '0;
            tbl_ready     <= 1'b0;
            flush_pending <= 1'b0;
            cfg_rsp_valid <= 1'b0;
            cfg_rsp_data  <= '0;
            collision_cnt <= '0;
            rd_addr       <= '0;
            rd_cnt        <= '0;
            rsp_is_read   <= 1'b0;
            byp_hit       <= 1'b0;
            byp_data      <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_req_valid && state == IDLE && bcd_valid && collision_cnt != '1) begin
                collision_cnt <= collision_cnt + 1'b1;
            end
            unique case (state)
                INIT: begin
                    // A flush during the sweep restarts it from entry 0.
                    if (flush_req) begin
                        ptr <= '0;
                    end else if (sweep_step) begin
                        ptr <= ptr + 1'b1;
                        if (sweep_last) begin
                            tbl_ready <= 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (flush_any) begin
                        tbl_ready     <= 1'b0;
                        ptr           <= '0;
                        flush_pending <= 1'b0;
                    end else if (accept) begin
                        rsp_is_read <= !cfg_req_wr;
                        if (cfg_req_wr) begin
                            cfg_rsp_data  <= cfg_req_wdata;
                            cfg_rsp_valid <= 1'b1;
                        end else begin
                            rd_addr <= cfg_req_addr;
                            rd_cnt  <= '0;
                            byp_hit <= 1'b0;
                        end
                    end
                end
                RD_WAIT: begin
                    flush_pending <= flush_pending | flush_req;
                    rd_cnt        <= rd_cnt + 1'b1;
                    if (bcd_hit) begin
                        byp_hit  <= 1'b1;
                        byp_data <= bcd_flowstate;
                    end
                    // Newest write-back to the read address wins over RAM data.
                    if (rd_capture) begin
                        cfg_rsp_valid <= 1'b1;
                        cfg_rsp_data  <= bcd_hit ? bcd_flowstate :
                                         byp_hit ? byp_data : mem_rd_data;
                    end
                end
                RSP: begin
                    if (rsp_is_read && bcd_hit) begin
                        cfg_rsp_data <= bcd_flowstate;
                    end
                    if (cfg_rsp_ready) begin
                        cfg_rsp_valid <= 1'b0;
                    end
                    if (cfg_rsp_ready && flush_pending) begin
                        tbl_ready     <= 1'b0;
                        ptr           <= '0;
                        flush_pending <= 1'b0;
                    end else begin
                        flush_pending <= flush_pending | flush_req;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mau_reli_tx_flowstate_arbiter.sv
// Directed bench for mau_reli_tx_flowstate_arbiter with a behavioural port-B RAM
// (1-cycle read latency) and a table of control-plane transactions.
module tb_mau_reli_tx_flowstate_arbiter;

    localparam int W     = 33;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int NEVER = 100000;

    logic          clk;
    logic          rst_n;
    logic          bcd_valid;
    logic [AW-1:0] bcd_addr;
    logic [W-1:0]  bcd_flowstate;
    logic          cfg_req_valid;
    logic          cfg_req_ready;
    logic          cfg_req_wr;
    logic [AW-1:0] cfg_req_addr;
    logic [W-1:0]  cfg_req_wdata;
    logic          cfg_rsp_valid;
    logic          cfg_rsp_ready;
    logic [W-1:0]  cfg_rsp_data;
    logic          flush_req;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [W-1:0]  mem_wr_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [W-1:0]  mem_rd_data;
    logic          tbl_ready;
    logic [15:0]   collision_cnt;

    int checks = 0;
    int errors = 0;

    mau_reli_tx_flowstate_arbiter #(
        .FLOWSTATE_WIDTH(W),
        .ADDR_WIDTH(AW),
        .RD_LATENCY(1),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bcd_valid(bcd_valid),
        .bcd_addr(bcd_addr),
        .bcd_flowstate(bcd_flowstate),
        .cfg_req_valid(cfg_req_valid),
        .cfg_req_ready(cfg_req_ready),
        .cfg_req_wr(cfg_req_wr),
        .cfg_req_addr(cfg_req_addr),
        .cfg_req_wdata(cfg_req_wdata),
        .cfg_rsp_valid(cfg_rsp_valid),
        .cfg_rsp_ready(cfg_rsp_ready),
        .cfg_rsp_data(cfg_rsp_data),
        .flush_req(flush_req),
        .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .tbl_ready(tbl_ready),
        .collision_cnt(collision_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port-B RAM; refilled with non-zero junk while reset is held so the
    // sweep has something to clear.
    logic [W-1:0] ram [DEPTH];
    logic [W-1:0] rd_q;
    assign mem_rd_data = rd_q;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= W'(33'h1_DEAD_0000) | W'(i);
        end else begin
            if (mem_rd_en) rd_q <= ram[mem_rd_addr];
            if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
        end
    end

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
        int            bcd_off;
        logic [AW-1:0] bcd_addr;
        logic [W-1:0]  bcd_data;
        logic [W-1:0]  exp_data;
        int            exp_lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, 64'({cfg_req_ready, cfg_rsp_valid, tbl_ready, mem_wr_en, mem_rd_en}), 64'd0);
        check({tag, "_rsp_data"}, 64'(cfg_rsp_data), 64'd0);
        check({tag, "_coll"}, 64'(collision_cnt), 64'd0);
    endtask

    // Runs one clear sweep from its first cycle until tbl_ready, verifying
    // every port-B write; returns the cycle tbl_ready was seen and a bad count.
    task automatic run_sweep(input int bcd_start, input int bcd_len, input logic [AW-1:0] baddr,
                             input logic [W-1:0] bdata, input int flush_at,
                             output int cycles, output int bad);
        int exp_ptr;
        exp_ptr = 0;
        cycles  = -1;
        bad     = 0;
        cfg_req_valid = 1'b1;
        cfg_req_wr    = 1'b0;
        cfg_req_addr  = '0;
        for (int c = 0; c < 3000; c++) begin
            bcd_valid     = (c >= bcd_start) && (c < bcd_start + bcd_len);
            bcd_addr      = baddr;
            bcd_flowstate = bdata;
            flush_req     = (c == flush_at);
            #1;
            if (tbl_ready) begin
                cycles = c;
                break;
            end
            if (cfg_req_ready || mem_rd_en) bad++;
            if (bcd_valid) begin
                if (!(mem_wr_en && mem_wr_addr == baddr && mem_wr_data == bdata)) bad++;
            end else begin
                if (!(mem_wr_en && mem_wr_addr == AW'(exp_ptr) && mem_wr_data == '0)) bad++;
                exp_ptr++;
            end
            if (c == flush_at) exp_ptr = 0;
            tick();
        end
        if (exp_ptr != DEPTH) bad++;
        bcd_valid     = 1'b0;
        flush_req     = 1'b0;
        cfg_req_valid = 1'b0;
    endtask

    // Presents one request until accepted and checks the port-B access it makes.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] wdata);
        bit acc;
        acc = 0;
        cfg_req_valid = 1'b1;
        cfg_req_wr    = wr;
        cfg_req_addr  = addr;
        cfg_req_wdata = wdata;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (cfg_req_ready) begin
                acc = 1;
                if (wr) check("accept_wr_port", 64'({mem_wr_en, mem_wr_addr, mem_wr_data}), 64'({1'b1, addr, wdata}));
                else    check("accept_rd_port", 64'({mem_rd_en, mem_rd_addr}), 64'({1'b1, addr}));
                tick();
                break;
            end
            tick();
        end
        cfg_req_valid = 1'b0;
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
    endtask

    // Waits for cfg_rsp_valid (optionally injecting one write-back), then handshakes.
    task automatic finish_rsp(input int bcd_off, input logic [AW-1:0] baddr, input logic [W-1:0] bdata,
                              output logic [W-1:0] rdata, output int lat);
        lat   = -1;
        rdata = '0;
        cfg_rsp_ready = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            bcd_valid     = (n == bcd_off);
            bcd_addr      = baddr;
            bcd_flowstate = bdata;
            #1;
            if (cfg_rsp_valid) begin
                lat   = n;
                rdata = cfg_rsp_data;
                break;
            end
            tick();
        end
        bcd_valid     = 1'b0;
        cfg_rsp_ready = 1'b1;
        tick();
        cfg_rsp_ready = 1'b0;
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (cfg_rsp_valid) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int           cyc, bad, lat;
        logic [W-1:0] rdata;

        vecs[0]  = '{1'b1, 10'd3,    33'h1_0000_0005, -1, 10'd0, 33'h0,           33'h1_0000_0005, 1};
        vecs[1]  = '{1'b0, 10'd3,    33'h0,           -1, 10'd0, 33'h0,           33'h1_0000_0005, 2};
        vecs[2]  = '{1'b0, 10'd9,    33'h0,            1, 10'd9, 33'h0_0000_0042, 33'h0_0000_0042, 2};
        vecs[3]  = '{1'b0, 10'd9,    33'h0,           -1, 10'd0, 33'h0,           33'h0_0000_0042, 2};
        vecs[4]  = '{1'b0, 10'd500,  33'h0,           -1, 10'd0, 33'h0,           33'h0,           2};
        vecs[5]  = '{1'b1, 10'd1023, 33'h0_FFFF_FFFF, -1, 10'd0, 33'h0,           33'h0_FFFF_FFFF, 1};
        vecs[6]  = '{1'b0, 10'd1023, 33'h0,           -1, 10'd0, 33'h0,           33'h0_FFFF_FFFF, 2};
        vecs[7]  = '{1'b0, 10'd0,    33'h0,           -1, 10'd0, 33'h0,           33'h0,           2};
        vecs[8]  = '{1'b1, 10'd0,    33'h1_FFFF_FFFF, -1, 10'd0, 33'h0,           33'h1_FFFF_FFFF, 1};
        vecs[9]  = '{1'b0, 10'd0,    33'h0,           -1, 10'd0, 33'h0,           33'h1_FFFF_FFFF, 2};
        vecs[10] = '{1'b0, 10'd3,    33'h0,            1, 10'd4, 33'h0_1234_5678, 33'h1_0000_0005, 2};
        vecs[11] = '{1'b0, 10'd4,    33'h0,           -1, 10'd0, 33'h0,           33'h0_1234_5678, 2};

        rst_n = 1'b0;
        bcd_valid = 1'b0; bcd_addr = '0; bcd_flowstate = '0;
        cfg_req_valid = 1'b0; cfg_req_wr = 1'b0; cfg_req_addr = '0; cfg_req_wdata = '0;
        cfg_rsp_ready = 1'b0; flush_req = 1'b0;
        repeat (3) tick();
        #1;
        check_reset_vals("reset");

        // Power-up sweep with no traffic.
        tick();
        rst_n = 1'b1;
        run_sweep(NEVER, 0, '0, '0, -1, cyc, bad);
        check("sweep0_cycles", 64'(cyc), 64'd1024);
        check("sweep0_bad", 64'(bad), 64'd0);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            finish_rsp(vecs[i].bcd_off, vecs[i].bcd_addr, vecs[i].bcd_data, rdata, lat);
            check($sformatf("vec%0d_data", i), 64'(rdata), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
        end

        // Request stalled by three write-back cycles.
        tick();
        cfg_req_valid = 1'b1; cfg_req_wr = 1'b0; cfg_req_addr = 10'd3;
        for (int i = 0; i < 3; i++) begin
            bcd_valid = 1'b1; bcd_addr = 10'd20; bcd_flowstate = 33'h0_0000_0011;
            #1;
            check($sformatf("stall%0d_ready", i), 64'(cfg_req_ready), 64'd0);
            tick();
        end
        bcd_valid = 1'b0;
        #1;
        check("stall_release", 64'({cfg_req_ready, mem_rd_en}), 64'b11);
        tick();
        cfg_req_valid = 1'b0;
        finish_rsp(-1, '0, '0, rdata, lat);
        check("stall_rd_data", 64'(rdata), 64'h1_0000_0005);
        check("collision_cnt", 64'(collision_cnt), 64'd3);

        // Write ack must not be touched by a write-back to the same address.
        issue(1'b1, 10'd30, 33'h0_0000_0005);
        wait_valid();
        bcd_valid = 1'b1; bcd_addr = 10'd30; bcd_flowstate = 33'h0_0000_0006;
        tick();
        bcd_valid = 1'b0;
        #1;
        check("wack_hold", 64'({cfg_rsp_valid, cfg_rsp_data}), 64'({1'b1, 33'h0_0000_0005}));
        cfg_rsp_ready = 1'b1;
        tick();
        cfg_rsp_ready = 1'b0;

        // Held read response: bypass, other-address write-back, then flush.
        issue(1'b0, 10'd20, '0);
        wait_valid();
        check("rd20_data", 64'(cfg_rsp_data), 64'h0_0000_0011);
        bcd_valid = 1'b1; bcd_addr = 10'd20; bcd_flowstate = 33'h0_0000_0099;
        tick();
        bcd_valid = 1'b0;
        #1;
        check("rsp_bypass", 64'({cfg_rsp_valid, cfg_rsp_data}), 64'({1'b1, 33'h0_0000_0099}));
        bcd_valid = 1'b1; bcd_addr = 10'd21; bcd_flowstate = 33'h0_0000_0077;
        tick();
        bcd_valid = 1'b0;
        #1;
        check("rsp_other_addr", 64'(cfg_rsp_data), 64'h0_0000_0099);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        #1;
        check("flush_hold", 64'({tbl_ready, cfg_rsp_valid, cfg_rsp_data}), 64'({2'b11, 33'h0_0000_0099}));
        cfg_rsp_ready = 1'b1;
        tick();
        cfg_rsp_ready = 1'b0;
        #1;
        check("flush_tbl_clear", 64'({tbl_ready, cfg_rsp_valid}), 64'd0);
        // Second flush inside the sweep restarts it at entry 0.
        run_sweep(NEVER, 0, '0, '0, 50, cyc, bad);
        check("sweep_restart_cycles", 64'(cyc), 64'd1075);
        check("sweep_restart_bad", 64'(bad), 64'd0);
        issue(1'b0, 10'd20, '0);
        finish_rsp(-1, '0, '0, rdata, lat);
        check("after_flush_rd20", 64'(rdata), 64'd0);

        // Flush seen in IDLE blocks the concurrent request.
        cfg_req_valid = 1'b1; cfg_req_wr = 1'b1; cfg_req_addr = 10'd5; cfg_req_wdata = 33'h1;
        flush_req = 1'b1;
        #1;
        check("flush_blocks_req", 64'(cfg_req_ready), 64'd0);
        tick();
        flush_req = 1'b0;
        cfg_req_valid = 1'b0;
        #1;
        check("idle_flush_tbl", 64'(tbl_ready), 64'd0);
        run_sweep(NEVER, 0, '0, '0, -1, cyc, bad);
        check("sweep_idleflush_cycles", 64'(cyc), 64'd1024);
        check("sweep_idleflush_bad", 64'(bad), 64'd0);

        // Leave a non-zero response register, then reset in the middle of a sweep.
        issue(1'b1, 10'd40, 33'h1_2345_6789);
        finish_rsp(-1, '0, '0, rdata, lat);
        check("wr40_ack", 64'(rdata), 64'h1_2345_6789);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (100) tick();
        rst_n = 1'b0;
        tick();
        #1;
        check_reset_vals("midsweep_reset");
        tick();
        rst_n = 1'b1;
        run_sweep(10, 5, 10'd7, 33'h1_0000_0777, -1, cyc, bad);
        check("sweep_bcd_cycles", 64'(cyc), 64'd1029);
        check("sweep_bcd_bad", 64'(bad), 64'd0);
        issue(1'b0, 10'd7, '0);
        finish_rsp(-1, '0, '0, rdata, lat);
        check("rd7_bcd_kept", 64'(rdata), 64'h1_0000_0777);
        issue(1'b0, 10'd500, '0);
        finish_rsp(-1, '0, '0, rdata, lat);
        check("rd500_cleared", 64'(rdata), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
